// File: rtl/accum_peripheral.sv
// accum_peripheral: multi-channel sample statistics peripheral with a
// shared sequential restoring divider for per-channel averages.
//
// Optional feature: define ACCUM_MINMAX_EN to keep per-channel MIN/MAX
// registers (offsets 4/5); without it those offsets read 0.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   CE     chip enable
//   PWE    write enable; a bus write happens when CE && PWE
//   addr   {channel, word offset[2:0]}
//   wdata  write data
//   rdata  combinational read of the addressed word (ignores CE)
//   busy   divider is iterating
//
// Word map per channel:
//   0 CTRL (wo)  bit0 clear ch, bit1 start avg, bit2 clear all
//   1 DATA       write accumulates, read returns last sample
//   2 SUM  3 COUNT  4 MIN  5 MAX  6 AVG  7 STATUS
//   STATUS: bit0 ovf, bit1 cnt_sat, bit2 busy, bit3 done, bit4 reject

module accum_peripheral #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16,
  parameter int NCH = 4,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int ADDR_W = (NCH > 1) ? $clog2(NCH) + 3 : 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CE,
  input  logic              PWE,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int BC_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t state, state_n;

  // address decode
  logic [CH_W-1:0] ch;
  logic [2:0]      off;

  generate
    if (NCH > 1) begin : g_ch
      assign ch = addr[ADDR_W-1:3];
    end else begin : g_ch1
      assign ch = '0;
    end
  endgenerate

  assign off = addr[2:0];

  // per-channel storage
  logic [DATA_W-1:0] last [NCH];
  logic [DATA_W-1:0] sum  [NCH];
  logic [DATA_W-1:0] avg  [NCH];
  logic [CNT_W-1:0]  cnt  [NCH];
  logic [NCH-1:0]    ovf;
  logic [NCH-1:0]    csat;
  logic [NCH-1:0]    done;
  logic [NCH-1:0]    rej;
`ifdef ACCUM_MINMAX_EN
  logic [DATA_W-1:0] mn [NCH];
  logic [DATA_W-1:0] mx [NCH];
`endif

  // divider datapath; dvd doubles as the quotient shift register
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] rem;
  logic [BC_W-1:0]   bit_cnt;
  logic [CH_W-1:0]   div_ch;

  // bus commands
  logic wr;
  logic ctrl_wr;
  logic data_wr;
  logic clr_all;
  logic clr_ch;
  logic start;
  logic start_go;
  logic start_zero;
  logic start_rej;
  logic abort;
  logic last_it;

  assign wr      = CE && PWE;
  assign ctrl_wr = wr && (off == 3'd0);
  assign data_wr = wr && (off == 3'd1);
  assign clr_all = ctrl_wr && wdata[2];
  assign clr_ch  = ctrl_wr && wdata[0];

  // a clear in the same write wins over start
  assign start = ctrl_wr && wdata[1] && !clr_all && !clr_ch;

  assign start_zero = start && (cnt[ch] == '0);
  assign start_go   = start && !start_zero && (state == IDLE);
  assign start_rej  = start && !start_zero && (state != IDLE);

  assign abort = (state != IDLE) &&
                 (clr_all || (clr_ch && (ch == div_ch)));

  assign last_it = (state == DIV) &&
                   (bit_cnt == BC_W'(DATA_W - 1));

  // one restoring step
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   diff;
  logic              qbit;
  logic [DATA_W-1:0] rem_n;
  logic [DATA_W-1:0] q_next;

  assign rem_sh = {rem, dvd[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign qbit   = ~diff[DATA_W];
  assign rem_n  = qbit ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
  assign q_next = (dvd << 1) | DATA_W'(qbit);

  // accumulate helpers for the addressed channel
  logic [DATA_W:0] sum_add;
  logic            cnt_full;

  assign sum_add  = {1'b0, sum[ch]} + {1'b0, wdata};
  assign cnt_full = &cnt[ch];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state / outputs
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_go) state_n = DIV;
      end
      DIV: begin
        busy = 1'b1;
        if (abort)        state_n = IDLE;
        else if (last_it) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // divider datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      bit_cnt <= '0;
      div_ch  <= '0;
    end else if (start_go) begin
      dvd     <= sum[ch];
      dvs     <= DATA_W'(cnt[ch]);
      rem     <= '0;
      bit_cnt <= '0;
      div_ch  <= ch;
    end else if (abort) begin
      dvd     <= '0;
      rem     <= '0;
      bit_cnt <= '0;
    end else if (state == DIV) begin
      dvd     <= q_next;
      rem     <= rem_n;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // channel registers; clear beats every other update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        last[c] <= '0;
        sum[c]  <= '0;
        avg[c]  <= '0;
        cnt[c]  <= '0;
`ifdef ACCUM_MINMAX_EN
        mn[c]   <= '1;
        mx[c]   <= '0;
`endif
      end
      ovf  <= '0;
      csat <= '0;
      done <= '0;
      rej  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (clr_all || (clr_ch && (ch == CH_W'(c)))) begin
          last[c] <= '0;
          sum[c]  <= '0;
          avg[c]  <= '0;
          cnt[c]  <= '0;
`ifdef ACCUM_MINMAX_EN
          mn[c]   <= '1;
          mx[c]   <= '0;
`endif
          ovf[c]  <= 1'b0;
          csat[c] <= 1'b0;
          done[c] <= 1'b0;
          rej[c]  <= 1'b0;
        end else begin
          if (data_wr && (ch == CH_W'(c))) begin
            last[c] <= wdata;
            if (sum_add[DATA_W]) begin
              sum[c] <= '1;
              ovf[c] <= 1'b1;
            end else begin
              sum[c] <= sum_add[DATA_W-1:0];
            end
            if (cnt_full) begin
              csat[c] <= 1'b1;
            end else begin
              cnt[c] <= cnt[c] + 1'b1;
            end
`ifdef ACCUM_MINMAX_EN
            if (wdata < mn[c]) mn[c] <= wdata;
            if (wdata > mx[c]) mx[c] <= wdata;
`endif
          end
          if (start_go && (ch == CH_W'(c))) begin
            done[c] <= 1'b0;
            rej[c]  <= 1'b0;
          end
          if (start_zero && (ch == CH_W'(c))) begin
            avg[c]  <= '0;
            done[c] <= 1'b1;
          end
          if (start_rej && (ch == CH_W'(c))) begin
            rej[c] <= 1'b1;
          end
          if (last_it && (div_ch == CH_W'(c))) begin
            avg[c] <= q_next;
          end
          if ((state == DONE) && (div_ch == CH_W'(c))) begin
            done[c] <= 1'b1;
          end
        end
      end
    end
  end

  // read mux
  logic [DATA_W-1:0] st;

  always_comb begin
    st    = '0;
    st[0] = ovf[ch];
    st[1] = csat[ch];
    st[2] = (state == DIV) && (div_ch == ch);
    st[3] = done[ch];
    st[4] = rej[ch];
  end

  always_comb begin
    rdata = '0;
    case (off)
      3'd1: rdata = last[ch];
      3'd2: rdata = sum[ch];
      3'd3: rdata = DATA_W'(cnt[ch]);
`ifdef ACCUM_MINMAX_EN
      3'd4: rdata = mn[ch];
      3'd5: rdata = mx[ch];
`endif
      3'd6: rdata = avg[ch];
      3'd7: rdata = st;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_accum_peripheral.sv
// tb_accum_peripheral: directed self-checking bench for accum_peripheral
// (DATA_W=32, CNT_W=16, NCH=4), hand-computed expectations.

module tb_accum_peripheral;

  localparam int DW = 32;

`ifdef ACCUM_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        CE;
  logic        PWE;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;

  int checks = 0;
  int failures = 0;

  accum_peripheral #(
    .DATA_W(32),
    .CNT_W(16),
    .NCH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .CE(CE),
    .PWE(PWE),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input int c, input int o, input logic [31:0] d);
    @(negedge clk);
    addr  = 5'(c * 8 + o);
    wdata = d;
    CE    = 1'b1;
    PWE   = 1'b1;
    @(posedge clk);
    #1;
    CE  = 1'b0;
    PWE = 1'b0;
  endtask

  task automatic rd(input int c, input int o, input string tag,
                    input logic [31:0] exp);
    @(negedge clk);
    addr = 5'(c * 8 + o);
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    int nb;
    logic [31:0] e;
    rst   = 1'b1;
    CE    = 1'b0;
    PWE   = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("busy_reset", 32'(busy), 32'd0);

    // reset values of every word
    for (int c = 0; c < 4; c++) begin
      for (int o = 0; o < 8; o++) begin
        e = (o == 4 && MM) ? 32'hFFFF_FFFF : 32'd0;
        rd(c, o, $sformatf("rst_ch%0d_off%0d", c, o), e);
      end
    end

    // channel 1 average of 10,20,30
    bus_write(1, 1, 32'd10);
    bus_write(1, 1, 32'd20);
    bus_write(1, 1, 32'd30);
    rd(1, 1, "ch1_last", 32'd30);
    rd(1, 2, "ch1_sum", 32'd60);
    rd(1, 3, "ch1_count", 32'd3);
    rd(1, 4, "ch1_min", MM ? 32'd10 : 32'd0);
    rd(1, 5, "ch1_max", MM ? 32'd30 : 32'd0);
    rd(1, 0, "ch1_ctrl_read", 32'd0);
    bus_write(1, 0, 32'h2);
    check("ch1_busy_start", 32'(busy), 32'd1);
    addr = 5'(1 * 8 + 7);
    #1;
    check("ch1_status_busy", rdata, 32'h4);
    addr = 5'(1 * 8 + 6);
    nb = busy ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (busy) nb++;
      if (i == DW + 2) check("ch1_avg_latency", rdata, 32'd20);
    end
    check("ch1_busy_cycles", 32'(nb), 32'd32);
    rd(1, 6, "ch1_avg", 32'd20);
    rd(1, 7, "ch1_status_done", 32'h8);

    // channel 0 sum saturation
    bus_write(0, 1, 32'hFFFF_FFF0);
    bus_write(0, 1, 32'h20);
    rd(0, 2, "ch0_sum_sat", 32'hFFFF_FFFF);
    rd(0, 7, "ch0_status_ovf", 32'h1);
    bus_write(0, 1, 32'h1);
    rd(0, 2, "ch0_sum_hold", 32'hFFFF_FFFF);
    rd(0, 3, "ch0_count", 32'd3);
    rd(0, 4, "ch0_min", MM ? 32'd1 : 32'd0);
    rd(0, 5, "ch0_max", MM ? 32'hFFFF_FFF0 : 32'd0);
    bus_write(0, 2, 32'h1234);
    bus_write(0, 3, 32'h55);
    rd(0, 2, "ch0_sum_ro", 32'hFFFF_FFFF);
    rd(0, 3, "ch0_count_ro", 32'd3);

    // channel 2 divides while channel 3 start is rejected
    for (int k = 7; k <= 11; k++) bus_write(2, 1, 32'(k));
    for (int k = 0; k < 4; k++) bus_write(3, 1, 32'd100);
    rd(2, 2, "ch2_sum", 32'd45);
    rd(3, 3, "ch3_count", 32'd4);
    bus_write(2, 0, 32'h2);
    @(posedge clk);
    bus_write(3, 0, 32'h2);
    rd(3, 7, "ch3_reject", 32'h10);
    rd(2, 7, "ch2_status_busy", 32'h4);
    repeat (40) @(posedge clk);
    rd(2, 6, "ch2_avg", 32'd9);
    rd(2, 7, "ch2_status_done", 32'h8);
    rd(3, 6, "ch3_avg_unchanged", 32'd0);
    rd(3, 7, "ch3_status_after", 32'h10);
    rd(3, 2, "ch3_sum", 32'd400);

    // abort channel 1 division at DIV cycle 10
    bus_write(1, 0, 32'h2);
    repeat (9) @(posedge clk);
    #1;
    check("ch1_busy_pre_abort", 32'(busy), 32'd1);
    bus_write(1, 0, 32'h1);
    check("ch1_busy_abort", 32'(busy), 32'd0);
    rd(1, 6, "ch1_avg_abort", 32'd0);
    rd(1, 2, "ch1_sum_abort", 32'd0);
    rd(1, 3, "ch1_count_abort", 32'd0);
    rd(1, 7, "ch1_status_abort", 32'h0);
    repeat (40) @(posedge clk);
    rd(1, 7, "ch1_status_late", 32'h0);
    rd(1, 6, "ch1_avg_late", 32'd0);

    // clear all with every channel populated
    bus_write(1, 1, 32'd5);
    rd(1, 3, "ch1_repop", 32'd1);
    bus_write(2, 0, 32'h4);
    for (int c = 0; c < 4; c++) begin
      rd(c, 2, $sformatf("clrall_sum_ch%0d", c), 32'd0);
      rd(c, 3, $sformatf("clrall_cnt_ch%0d", c), 32'd0);
      rd(c, 7, $sformatf("clrall_st_ch%0d", c), 32'd0);
      rd(c, 6, $sformatf("clrall_avg_ch%0d", c), 32'd0);
    end

    // start with COUNT=0: immediate done, no busy
    bus_write(0, 0, 32'h2);
    check("zero_busy", 32'(busy), 32'd0);
    addr = 5'(0 * 8 + 7);
    #1;
    check("zero_status_done", rdata, 32'h8);
    nb = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (busy) nb++;
    end
    check("zero_busy_never", 32'(nb), 32'd0);
    rd(0, 6, "zero_avg", 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accum_peripheral.md
Name: accum_peripheral

Overview:
- Memory-mapped, multi-channel statistics peripheral on the processor's single-cycle peripheral bus.
- Each of NCH channels accumulates written samples into sum and count registers, with sticky overflow and saturation flags.
- A shared sequential restoring divider computes a per-channel average on request.
- Generalised successor of the team's 4-word accumulator peripheral: parametrised width and channel count, per-channel windows, divider state machine.

Parameters:
- DATA_W, 32, sample, sum, avg and bus data width.
- CNT_W, 16, count register width; must satisfy CNT_W <= DATA_W.
- NCH, 4, number of channels; power of two, >= 1.
- ADDR_W, $clog2(NCH)+3 (use 3 when NCH=1), bus address width; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- CE  input  1  chip enable.
- PWE  input  1  peripheral write enable; a write occurs when CE && PWE.
- addr  input  ADDR_W  addr[ADDR_W-1:3] = channel, addr[2:0] = word offset.
- wdata  input  DATA_W  write data.
- rdata  output  DATA_W  combinational read of the addressed word, independent of CE.
- busy  output  1  divider active.

Behaviour:
- Word map per channel:
  - 0 CTRL: write-only, reads 0. bit0 = clear channel, bit1 = start average, bit2 = clear all channels.
  - 1 DATA: write accumulates; read returns last sample.
  - 2 SUM, 3 COUNT (zero-extended), 4 MIN, 5 MAX, 6 AVG: read-only.
  - 7 STATUS: read-only. bit0 ovf, bit1 cnt_sat, bit2 busy (this channel being divided), bit3 done, bit4 reject. Other bits 0.
  - Writes to read-only offsets are ignored.
- Reset and clear:
  - Reset: every register, flag and divider state is 0, except MIN = all-ones. busy=0.
  - Clear (bit0, or bit2 for all channels) restores the same values on the next edge.
  - Clear has priority over a same-cycle start and over all other updates to that channel.
- DATA write of value w to channel c, on one edge:
  - last <= w.
  - SUM <= SUM+w, unsigned. If the carry out of DATA_W bits is set, SUM <= all-ones and ovf <= 1. ovf is sticky; SUM stays saturated.
  - COUNT <= COUNT+1. If COUNT is already all-ones it holds and cnt_sat <= 1 (sticky).
  - MIN/MAX updated (see Optional Feature).
- Start (bit1) on channel c:
  - If the divider is idle and COUNT != 0: latch the SUM and COUNT snapshot; clear done and reject; go to DIV. busy=1 from the next cycle.
  - If COUNT == 0: AVG <= 0 and done <= 1 on the same edge; no busy cycles.
  - If the divider is busy: start is ignored and reject <= 1 on channel c. The in-flight division is unaffected.
- Divider FSM:
  - States: IDLE, DIV, DONE.
  - DIV runs exactly DATA_W cycles, one restoring quotient bit per cycle, MSB first, truncating.
  - DIV -> DONE: AVG[ch] <= quotient.
  - DONE lasts one cycle: done <= 1, then back to IDLE.
  - Result is readable DATA_W+2 edges after the start edge.
- DATA writes to the channel under division update SUM/COUNT normally; the quotient uses the snapshot.
- Clear of the channel under division (bit0 or bit2) aborts: FSM -> IDLE, busy=0, AVG=0, done=0.
- Asynchronous reset mid-division returns to IDLE immediately.
- Out-of-range behaviour: none; all addresses decode.

Optional Feature:
- Macro: ACCUM_MINMAX_EN.
- Defined:
  - A DATA write updates MIN <= min(MIN,w) and MAX <= max(MAX,w), unsigned.
  - MIN/MAX read via offsets 4/5.
- Undefined:
  - No MIN/MAX storage.
  - Offsets 4/5 read 0.

Test Plan:
- Reset, then read all 8 offsets of each channel -> all 0, except MIN = 0xFFFFFFFF when ACCUM_MINMAX_EN is defined (0 otherwise).
- Channel 1: write DATA 10, 20, 30, then start -> SUM=60, COUNT=3, busy high for 32 cycles, AVG=20, STATUS done=1; MIN=10, MAX=30 with the macro.
- Channel 0: write DATA 0xFFFFFFF0 then 0x20 -> SUM=0xFFFFFFFF, ovf=1; a further write of 1 keeps SUM=0xFFFFFFFF, COUNT=3.
- Start on ch2 (COUNT=5), then start on ch3 two cycles later -> ch3 reject=1, ch2 AVG correct, ch3 AVG unchanged.
- Start on ch1, write CTRL bit0 to ch1 at DIV cycle 10 -> busy=0 next cycle, AVG=0, SUM=0, COUNT=0, done stays 0.
- Write CTRL=0x4 to any channel with all channels populated -> every channel's SUM, COUNT and flags read 0 next cycle. Start with COUNT=0 -> AVG=0, done=1 after one edge, busy never asserted.
